// File: rtl/tx_sym_pkg.sv
// Shared types and constants for the TX symbol scheduler.
package tx_sym_pkg;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DATA  = 2'd2,
    ST_SYNC  = 2'd3
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;

  // One encoder symbol: K flag plus byte.
  typedef struct packed {
    logic       k;
    logic [7:0] data;
  } sym_t;

  function automatic sym_t comma_sym();
    sym_t s;
    s.k    = 1'b1;
    s.data = K28_5;
    return s;
  endfunction

  function automatic sym_t data_sym(input logic [7:0] b);
    sym_t s;
    s.k    = 1'b0;
    s.data = b;
    return s;
  endfunction

endpackage

// File: rtl/tx_sym_cnt.sv
// Saturating, loadable symbol counter with terminal-count flag at MAX.
module tx_sym_cnt #(
  parameter int W   = 16,
  parameter int MAX = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_inc,
  output logic         o_tc
);

  logic [W-1:0] cnt;

  // clear beats load beats increment; increment stops at MAX so it never wraps
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         cnt <= '0;
    else if (i_clr)                       cnt <= '0;
    else if (i_ld)                        cnt <= i_ld_val;
    else if (i_inc && (cnt != W'(MAX)))   cnt <= cnt + 1'b1;
  end

  assign o_tc = (cnt == W'(MAX));

endmodule

// File: rtl/tx_comma_sched.sv
// TX scheduler: muxes MAC bytes with K28.5 training/sync commas and owns
// the polarity-comma replacer enable so it only changes under commas.
module tx_comma_sched
  import tx_sym_pkg::*;
#(
  parameter int PREAMBLE_LEN = 16,
  parameter int COMMA_PERIOD = 256,
  parameter int BURST_LEN    = 2,
  parameter int CNT_W        = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sym_stb,
  input  logic       i_man_en,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic [7:0] o_enc_data,
  output logic       o_enc_k,
  output logic       o_pol_en,
  output logic [1:0] o_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int BURST_MAX = (BURST_LEN > 1) ? BURST_LEN - 1 : 0;

  state_t state, state_n;
  sym_t   sym_q, sym_n;
  logic   mode_chg, pol_arm;
  logic   train_tc, data_tc, burst_tc;
  logic   train_inc, train_clr;
  logic   data_ld, data_inc, data_clr;
  logic   burst_ld, burst_inc, burst_clr;

  assign mode_chg = (i_man_en != o_pol_en);

  // train_cnt: commas sent in TRAIN, tc on the last preamble comma
  tx_sym_cnt #(.W(CNT_W), .MAX(PREAMBLE_LEN - 1)) u_train_cnt (
    .i_clk, .i_rst_n,
    .i_clr(i_sym_stb & train_clr), .i_ld(1'b0), .i_ld_val('0),
    .i_inc(i_sym_stb & train_inc), .o_tc(train_tc)
  );

  // data_cnt: consecutive data symbols, tc forces a sync burst
  tx_sym_cnt #(.W(CNT_W), .MAX(COMMA_PERIOD)) u_data_cnt (
    .i_clk, .i_rst_n,
    .i_clr(i_sym_stb & data_clr), .i_ld(i_sym_stb & data_ld), .i_ld_val(CNT_ONE),
    .i_inc(i_sym_stb & data_inc), .o_tc(data_tc)
  );

  // burst_cnt: commas in the current sync burst, tc on the last one
  tx_sym_cnt #(.W(CNT_W), .MAX(BURST_MAX)) u_burst_cnt (
    .i_clk, .i_rst_n,
    .i_clr(i_sym_stb & burst_clr), .i_ld(i_sym_stb & burst_ld), .i_ld_val(CNT_ONE),
    .i_inc(i_sym_stb & burst_inc), .o_tc(burst_tc)
  );

  // next state, next symbol and counter controls (applied only on strobes)
  always_comb begin
    state_n   = state;
    sym_n     = comma_sym();
    train_inc = 1'b0;
    train_clr = 1'b0;
    data_ld   = 1'b0;
    data_inc  = 1'b0;
    data_clr  = 1'b1;
    burst_ld  = 1'b0;
    burst_inc = 1'b0;
    burst_clr = 1'b0;
    unique case (state)
      ST_TRAIN: begin
        train_inc = 1'b1;
        if (train_tc) begin
          train_clr = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (mode_chg) begin
          state_n = ST_TRAIN;
        end else if (i_tx_valid) begin
          sym_n    = data_sym(i_tx_data);
          data_clr = 1'b0;
          data_ld  = 1'b1;
          state_n  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mode_chg) begin
          state_n = ST_TRAIN;
        end else if (data_tc) begin
          if (BURST_LEN == 1) begin
            state_n = ST_IDLE;
          end else begin
            burst_ld = 1'b1;
            state_n  = ST_SYNC;
          end
        end else if (i_tx_valid) begin
          sym_n    = data_sym(i_tx_data);
          data_clr = 1'b0;
          data_inc = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (mode_chg) begin
          burst_clr = 1'b1;
          state_n   = ST_TRAIN;
        end else if (burst_tc) begin
          burst_clr = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          burst_inc = 1'b1;
        end
      end
      default: state_n = ST_TRAIN;
    endcase
  end

  // state, registered symbol, pol enable; all advance only on a strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_TRAIN;
      sym_q    <= comma_sym();
      o_pol_en <= 1'b0;
      pol_arm  <= 1'b1;
    end else if (i_sym_stb) begin
      state   <= state_n;
      sym_q   <= sym_n;
      // arm on TRAIN entry so the first TRAIN strobe (a comma) samples the mode
      pol_arm <= (state_n == ST_TRAIN) && (state != ST_TRAIN);
      if (state == ST_TRAIN && pol_arm) o_pol_en <= i_man_en;
    end
  end

  assign o_tx_ready = i_sym_stb & ((state == ST_IDLE) | (state == ST_DATA)) & ~mode_chg &
                      ~((state == ST_DATA) & data_tc);
  assign o_enc_data = sym_q.data;
  assign o_enc_k    = sym_q.k;
  assign o_state    = state;

endmodule

// File: doc/tx_comma_sched.md
Name: tx_comma_sched

Overview:
- Symbol-level TX scheduler ahead of the 8b10b encoder and the polarity-comma replacer.
- Multiplexes the MAC byte stream with K28.5 idle/sync commas:
  - forces a training preamble after reset and after any Manchester mode change;
  - inserts a periodic comma burst so the receiver keeps polarity lock.
- Owns the replacer's enable (o_pol_en) and changes it only while commas are being emitted.
- This keeps the replacer's 0→1-cycle latency change from corrupting data symbols.

Parameters:
- PREAMBLE_LEN, 16, commas sent in TRAIN (≥2)
- COMMA_PERIOD, 256, max consecutive data symbols before a forced sync burst (≥2)
- BURST_LEN, 2, commas per sync burst (≥1)
- CNT_W, 16, counter width; must hold max(PREAMBLE_LEN, COMMA_PERIOD)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_sym_stb  in  1  symbol strobe, one pulse per encoder symbol slot; all state advances only on it
- i_man_en  in  1  requested Manchester/polarity-comma mode (quasi-static, synchronous)
- i_tx_valid  in  1  MAC byte valid
- i_tx_data  in  8  MAC byte
- o_tx_ready  out  1  byte accepted this cycle when i_tx_valid & o_tx_ready
- o_enc_data  out  8  byte to 8b10b encoder
- o_enc_k  out  1  K-char flag to encoder
- o_pol_en  out  1  enable for polarity-comma replacer
- o_state  out  2  FSM state, for debug/status

Behaviour:
- Reset values:
  - o_enc_data = 8'hBC and o_enc_k = 1 (K28.5)
  - o_pol_en = 0, o_tx_ready = 0
  - state = TRAIN, all counters 0
- Encoding: o_state TRAIN=0, IDLE=1, DATA=2, SYNC=3.
- o_enc_data/o_enc_k are registered and update only on i_sym_stb; one-cycle latency from acceptance to output.
- Comma = {k=1, 8'hBC}. Data = {k=0, byte}.
- o_tx_ready is combinational: i_sym_stb & (state==IDLE | state==DATA) & ~mode_chg & ~(state==DATA & data_cnt==COMMA_PERIOD). Byte is accepted only in the strobe cycle.
- mode_chg = (i_man_en != o_pol_en).
- TRAIN:
  - emits a comma each strobe; train_cnt increments.
  - o_pol_en <= i_man_en on the first strobe of TRAIN.
  - after PREAMBLE_LEN commas → IDLE.
- IDLE:
  - if mode_chg → TRAIN (comma emitted).
  - else if i_tx_valid → emit byte, data_cnt=1, → DATA.
  - else emit comma.
- DATA:
  - precedence: mode_chg > period expiry > valid.
  - mode_chg → emit comma, → TRAIN.
  - data_cnt==COMMA_PERIOD → emit comma, burst_cnt=1, → SYNC (or IDLE if BURST_LEN==1).
  - i_tx_valid → emit byte, data_cnt++.
  - ~i_tx_valid → emit comma, → IDLE.
- SYNC:
  - emits commas; after BURST_LEN total → IDLE.
  - mode_chg mid-burst → TRAIN.
- Any emitted comma clears data_cnt. Counters never wrap: data_cnt is bounded by COMMA_PERIOD.
- Between strobes, outputs and state hold and o_tx_ready=0.
- Strobe held high continuously is legal: one symbol per clock.
- Reset mid-frame: immediate async return to reset values. The in-flight byte is dropped; the MAC sees no accept.
- o_pol_en toggles only on a strobe in which a comma is being emitted (TRAIN entry). It never toggles adjacent to a data symbol without ≥1 comma in between.

Decomposition:
- Shared package tx_sym_pkg:
  - state enum
  - K28_5 = 8'hBC
  - symbol struct {k, data}
- Natural sub-module: tx_sym_cnt, a generic saturating/loadable counter with terminal-count flag. Instance it three times: train, data, burst.
- FSM and output mux stay in tx_comma_sched.

Test Plan:
- Reset release, i_man_en=1, strobe every 4 clk:
  - 16 commas (BC,k=1);
  - o_pol_en rises on the 1st TRAIN strobe;
  - o_state goes 0→1.
- IDLE, valid with bytes 0x00..0x09, strobe every clk:
  - encoder sees the 10 bytes k=0 in order, 1 cycle late;
  - ready only on strobes;
  - then a comma and return to IDLE.
- Continuous valid stream, COMMA_PERIOD=256:
  - after byte 256: 2 commas with ready low (SYNC);
  - byte 257 follows;
  - no byte lost or duplicated.
- Toggle i_man_en 1→0 at byte 100 of a stream:
  - next symbol is a comma;
  - 16-comma TRAIN;
  - o_pol_en falls on a comma strobe, never next to data.
- Async reset asserted mid-DATA between strobes:
  - outputs immediately BC/k=1, pol_en=0, ready=0;
  - TRAIN restarts on release.
- i_sym_stb tied low for 50 clk in DATA with valid high:
  - no accept;
  - o_enc_* and state frozen.
